disk_host_bridge: RTL and testbench
===================================

// Module: disk_host_bridge
// PURPOSE
//  Host-side byte bridge between the control microcontroller bus and the diskdrives block (ctrl-module side).
//  Buffers sector bytes host->drive (TX) and drive->host (RX) in small FIFOs; paces disk_data_clkin/clkout strobes.
//  Holds disk_cr shadow and exposes disk_sr snapshot bytes. One bridge serves both drives; diskdrives selects the target.
// PARAMETERS
//  FIFO_AW   4  log2 FIFO depth (16 bytes per direction)
//  PULSE_W   2  strobe high time, clk24 cycles (1..15)
//  GAP_W     4  minimum low time between consecutive strobes, clk24 cycles (1..15)
// PORTS
//  clk24            in   1   sole clock
//  rstn             in   1   synchronous active-low reset
//  host_addr        in   2   register select
//  host_wr          in   1   one-cycle write strobe
//  host_rd          in   1   one-cycle read strobe
//  host_din         in   8   write data
//  host_dout        out  8   read data, registered, valid cycle after host_rd
//  disk_data_in     out  8   byte to diskdrives, stable whole strobe
//  disk_data_clkin  out  1   write strobe to diskdrives
//  disk_data_out    in   8   byte from diskdrives
//  disk_data_clkout out  1   read strobe to diskdrives
//  disk_sr          in   32  drive status from diskdrives
//  disk_cr          out  32  drive control to diskdrives
//  sr_irq           out  1   only with DISK_BRIDGE_SR_IRQ_EN
// BEHAVIOUR
//  Reset: host_dout=0, disk_data_in=0, both strobes=0, disk_cr=0, FIFOs empty, rd_req=0, sr_ptr=0, FSM IDLE, sr_irq=0.
//  Registers: addr0 W push TX (dropped if full) / R pop RX (returns 8'h00, no pop, if empty).
//   addr1 W: bit0 flush TX+RX+rd_req (strobe in progress completes); bit1 rd_req+=1 (sat. 255); bit2 snapshot disk_sr, sr_ptr=0.
//   addr1 R: {tx_full,tx_empty,rx_full,rx_empty,busy,2'b0,rd_req!=0}.
//   addr2 W: cr_shadow={cr_shadow[23:0],din}; R: snapshot byte sr_ptr (0=LSB), sr_ptr wraps mod 4.
//   addr3 W: disk_cr<=cr_shadow next cycle; R: rd_req count.
//  FSM IDLE->WSTB->GAP->IDLE and IDLE->RSTB->GAP->IDLE.
//   IDLE: TX nonempty has priority: pop, load disk_data_in, ->WSTB. Else rd_req!=0 and RX not full -> RSTB.
//   WSTB: clkin high PULSE_W cycles; disk_data_in held through GAP.
//   RSTB: capture disk_data_out on entry cycle, push RX, rd_req-=1; clkout high PULSE_W cycles.
//   GAP: both strobes low GAP_W cycles; busy=1 in all states but IDLE.
//  Latency: TX push to clkin rise = 2 cycles when IDLE; strobe period PULSE_W+GAP_W+1.
//  Simultaneous host push+internal pop same FIFO: both take effect, count unchanged; pop-on-full/push-on-empty legal.
//  Full RX with rd_req pending: stall in IDLE, no strobe. Flush+bit1 same write: flush then rd_req=1.
//  rstn low mid-strobe: strobes drop next edge; partial byte discarded.
// CONFIGURATION
//  DISK_BRIDGE_SR_IRQ_EN defined: sr_irq set when disk_sr differs from previous cycle; cleared by addr1 write bit2.
//  Undefined: sr_irq port absent; disk_sr sampled only on snapshot.
// STRUCTURE
//  disk_bridge_pkg: register address localparams, addr1 bit indices, FSM state enum, status bit positions.
//  Sub-module bridge_byte_fifo (AW param, synchronous, registered count, full/empty); instantiated twice.
// TESTING
//  Push 8'hA5,8'h3C via addr0 -> two clkin pulses, PULSE_W=2 high, >=GAP_W low, disk_data_in A5 then 3C.
//  addr1 W 8'h02 x3 with disk_data_out stepping 11,22,33 per clkout -> RX pops 11,22,33; 4th pop returns 00.
//  Push 17 bytes with drive idle-stalled via constant IDLE? -> 17th push at full dropped, tx_full=1, 16 strobes total.
//  Write addr2 12,34,56,78 then addr3 -> disk_cr=32'h12345678 one cycle later; disk_sr=32'hDEADBEEF, bit2, 4 reads -> EF,BE,AD,DE.
//  TX and rd_req both pending -> all TX strobes precede first clkout; rstn low mid-WSTB -> clkin 0 next cycle, FIFOs empty.
//  DISK_BRIDGE_SR_IRQ_EN: toggle disk_sr bit5 -> sr_irq=1; addr1 W 8'h04 -> sr_irq=0.

Source files
------------

// File: rtl/disk_bridge_pkg.sv
// Shared definitions for the disk host bridge: register map, control bits,
// status bit positions, strobe-engine states and the status byte packer.
package disk_bridge_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_SR   = 2'd2;
  localparam logic [1:0] ADDR_CR   = 2'd3;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_RDREQ = 1;
  localparam int CTRL_SNAP  = 2;

  localparam int ST_TX_FULL  = 7;
  localparam int ST_TX_EMPTY = 6;
  localparam int ST_RX_FULL  = 5;
  localparam int ST_RX_EMPTY = 4;
  localparam int ST_BUSY     = 3;
  localparam int ST_RD_PEND  = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WSTB = 2'd1,
    S_RSTB = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  function automatic logic [7:0] status_byte(input logic tx_full, input logic tx_empty,
                                             input logic rx_full, input logic rx_empty,
                                             input logic busy, input logic rd_pend);
    logic [7:0] s;
    s = 8'h00;
    s[ST_TX_FULL]  = tx_full;
    s[ST_TX_EMPTY] = tx_empty;
    s[ST_RX_FULL]  = rx_full;
    s[ST_RX_EMPTY] = rx_empty;
    s[ST_BUSY]     = busy;
    s[ST_RD_PEND]  = rd_pend;
    return s;
  endfunction

endpackage

// File: rtl/bridge_byte_fifo.sv
// Synchronous byte FIFO with registered occupancy count; a pop frees a slot
// for a push in the same cycle, and flush empties it.
module bridge_byte_fifo #(
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  // Accept a push on a full FIFO only when a pop frees the slot this cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      else         wptr <= wptr;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      else         rptr <= rptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/disk_host_bridge.sv
// Host-side byte bridge to the diskdrives block: TX/RX byte FIFOs, strobe pacing,
// disk_cr shadow and disk_sr snapshot. Optional sr_irq with DISK_BRIDGE_SR_IRQ_EN.
module disk_host_bridge
  import disk_bridge_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 4
) (
  input  logic        clk24,
  input  logic        rstn,
  input  logic [1:0]  host_addr,
  input  logic        host_wr,
  input  logic        host_rd,
  input  logic [7:0]  host_din,
  output logic [7:0]  host_dout,
  output logic [7:0]  disk_data_in,
  output logic        disk_data_clkin,
  input  logic [7:0]  disk_data_out,
  output logic        disk_data_clkout,
  input  logic [31:0] disk_sr,
  output logic [31:0] disk_cr
`ifdef DISK_BRIDGE_SR_IRQ_EN
  ,
  output logic        sr_irq
`endif
);

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_W - 1);

  logic [7:0]  tx_dout, rx_dout;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic        flush, ctl_rdreq, ctl_snap, wr_sr, rd_sr, wr_cr, rd_dec;
  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [7:0]  rd_req;
  logic [31:0] cr_shadow, snap;
  logic [1:0]  sr_ptr;
  logic [7:0]  snap_byte, status;

  // Host register decode.
  always_comb begin
    tx_push   = host_wr && (host_addr == ADDR_DATA);
    rx_pop    = host_rd && (host_addr == ADDR_DATA) && !rx_empty;
    flush     = host_wr && (host_addr == ADDR_CTRL) && host_din[CTRL_FLUSH];
    ctl_rdreq = host_wr && (host_addr == ADDR_CTRL) && host_din[CTRL_RDREQ];
    ctl_snap  = host_wr && (host_addr == ADDR_CTRL) && host_din[CTRL_SNAP];
    wr_sr     = host_wr && (host_addr == ADDR_SR);
    rd_sr     = host_rd && (host_addr == ADDR_SR);
    wr_cr     = host_wr && (host_addr == ADDR_CR);
    status    = status_byte(tx_full, tx_empty, rx_full, rx_empty,
                            state != S_IDLE, rd_req != 8'd0);
    case (sr_ptr)
      2'd0:    snap_byte = snap[7:0];
      2'd1:    snap_byte = snap[15:8];
      2'd2:    snap_byte = snap[23:16];
      2'd3:    snap_byte = snap[31:24];
      default: snap_byte = 8'h00;
    endcase
  end

  bridge_byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk(clk24), .rstn(rstn), .flush(flush),
    .push(tx_push), .din(host_din), .pop(tx_pop),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  bridge_byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk(clk24), .rstn(rstn), .flush(flush),
    .push(rx_push), .din(disk_data_out), .pop(rx_pop),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  // Strobe engine state and phase counter.
  always_ff @(posedge clk24) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Strobe engine: TX drains before any pending read; reads stall while RX is full.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    rd_dec     = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_next = 4'd0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          state_next = S_WSTB;
        end else if ((rd_req != 8'd0) && !rx_full) begin
          rx_push    = 1'b1;
          rd_dec     = 1'b1;
          state_next = S_RSTB;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_WSTB, S_RSTB: begin
        if (cnt == PULSE_LAST) begin
          state_next = S_GAP;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_next = S_IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Strobes track the next state so they rise on the same edge the engine leaves IDLE.
  always_ff @(posedge clk24) begin
    if (!rstn) begin
      disk_data_in     <= 8'h00;
      disk_data_clkin  <= 1'b0;
      disk_data_clkout <= 1'b0;
    end else begin
      disk_data_in     <= tx_pop ? tx_dout : disk_data_in;
      disk_data_clkin  <= (state_next == S_WSTB);
      disk_data_clkout <= (state_next == S_RSTB);
    end
  end

  // Pending read-request counter; flush clears it before a same-write increment.
  always_ff @(posedge clk24) begin
    if (!rstn) begin
      rd_req <= 8'd0;
    end else if (flush) begin
      rd_req <= ctl_rdreq ? 8'd1 : 8'd0;
    end else begin
      case ({ctl_rdreq, rd_dec})
        2'b10:   rd_req <= (rd_req == 8'hFF) ? rd_req : rd_req + 8'd1;
        2'b01:   rd_req <= rd_req - 8'd1;
        default: rd_req <= rd_req;
      endcase
    end
  end

  // Host-visible registers and read data.
  always_ff @(posedge clk24) begin
    if (!rstn) begin
      host_dout <= 8'h00;
      cr_shadow <= 32'h0;
      disk_cr   <= 32'h0;
      snap      <= 32'h0;
      sr_ptr    <= 2'd0;
    end else begin
      cr_shadow <= wr_sr ? {cr_shadow[23:0], host_din} : cr_shadow;
      disk_cr   <= wr_cr ? cr_shadow : disk_cr;
      snap      <= ctl_snap ? disk_sr : snap;
      if (ctl_snap)   sr_ptr <= 2'd0;
      else if (rd_sr) sr_ptr <= sr_ptr + 2'd1;
      else            sr_ptr <= sr_ptr;
      if (host_rd) begin
        case (host_addr)
          ADDR_DATA: host_dout <= rx_empty ? 8'h00 : rx_dout;
          ADDR_CTRL: host_dout <= status;
          ADDR_SR:   host_dout <= snap_byte;
          ADDR_CR:   host_dout <= rd_req;
          default:   host_dout <= 8'h00;
        endcase
      end else begin
        host_dout <= host_dout;
      end
    end
  end

`ifdef DISK_BRIDGE_SR_IRQ_EN
  logic [31:0] sr_prev;

  // Status-change interrupt; a change in the same cycle as the clear wins.
  always_ff @(posedge clk24) begin
    sr_prev <= disk_sr;
    if (!rstn)                   sr_irq <= 1'b0;
    else if (disk_sr != sr_prev) sr_irq <= 1'b1;
    else if (ctl_snap)           sr_irq <= 1'b0;
    else                         sr_irq <= sr_irq;
  end
`endif

endmodule

// File: tb/tb_disk_host_bridge.sv
// Self-checking bench for disk_host_bridge: randomized TX streams checked against a
// queue-and-period model, plus directed RX, register, priority, stall and reset scenarios.
module tb_disk_host_bridge;
  import disk_bridge_pkg::*;

  localparam int FIFO_AW = 4;
  localparam int PULSE_W = 2;
  localparam int GAP_W   = 4;
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int PERIOD  = PULSE_W + GAP_W + 1;

  logic        clk24 = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  host_addr = 2'd0;
  logic        host_wr = 1'b0;
  logic        host_rd = 1'b0;
  logic [7:0]  host_din = 8'h00;
  logic [7:0]  host_dout;
  logic [7:0]  disk_data_in;
  logic        disk_data_clkin;
  logic [7:0]  disk_data_out = 8'h00;
  logic        disk_data_clkout;
  logic [31:0] disk_sr = 32'h0;
  logic [31:0] disk_cr;
`ifdef DISK_BRIDGE_SR_IRQ_EN
  logic        sr_irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  disk_host_bridge #(.FIFO_AW(FIFO_AW), .PULSE_W(PULSE_W), .GAP_W(GAP_W)) dut (
    .clk24(clk24), .rstn(rstn), .host_addr(host_addr), .host_wr(host_wr),
    .host_rd(host_rd), .host_din(host_din), .host_dout(host_dout),
    .disk_data_in(disk_data_in), .disk_data_clkin(disk_data_clkin),
    .disk_data_out(disk_data_out), .disk_data_clkout(disk_data_clkout),
    .disk_sr(disk_sr), .disk_cr(disk_cr)
`ifdef DISK_BRIDGE_SR_IRQ_EN
    , .sr_irq(sr_irq)
`endif
  );

  always #5 clk24 = ~clk24;

  // Strobe monitor: records bytes, pulse widths, low gaps and strobe order.
  logic [7:0] wq[$];
  int         wwid[$], rwid[$], gapq[$];
  bit         order_q[$];
  logic       p_in = 1'b0, p_out = 1'b0;
  int         hi_in = 0, hi_out = 0, low_run = 1000, stable_err = 0;
  logic [7:0] held = 8'h00;

  always @(negedge clk24) begin
    if (disk_data_clkin && !p_in) begin
      wq.push_back(disk_data_in); order_q.push_back(1'b0); gapq.push_back(low_run);
      hi_in <= 1; held <= disk_data_in;
    end else if (disk_data_clkin) begin
      hi_in <= hi_in + 1;
      if (disk_data_in !== held) stable_err <= stable_err + 1;
    end else if (p_in) wwid.push_back(hi_in);
    if (disk_data_clkout && !p_out) begin
      order_q.push_back(1'b1); gapq.push_back(low_run); hi_out <= 1;
    end else if (disk_data_clkout) hi_out <= hi_out + 1;
    else if (p_out) rwid.push_back(hi_out);
    if ((disk_data_clkin && !p_in) || (disk_data_clkout && !p_out)) low_run <= 0;
    else if (!disk_data_clkin && !disk_data_clkout) low_run <= low_run + 1;
    p_in  <= disk_data_clkin;
    p_out <= disk_data_clkout;
  end

  task automatic clear_mon();
    wq.delete(); wwid.delete(); rwid.delete(); gapq.delete(); order_q.delete();
  endtask

  task automatic tick();
    @(posedge clk24); #1;
  endtask

  task automatic host_write(input logic [1:0] a, input logic [7:0] d);
    host_addr = a; host_din = d; host_wr = 1'b1;
    tick();
    host_wr = 1'b0;
  endtask

  task automatic host_read(input logic [1:0] a, output logic [7:0] d);
    host_addr = a; host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    d = host_dout;
  endtask

  task automatic wait_idle(input int bound);
    logic [7:0] s;
    bit done;
    done = 1'b0;
    s = 8'h00;
    for (int i = 0; i < bound && !done; i++) begin
      host_read(ADDR_CTRL, s);
      if (!s[ST_BUSY] && s[ST_TX_EMPTY] && (!s[ST_RD_PEND] || s[ST_RX_FULL])) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL wait_idle: got status %h after %0d reads, required idle", s, bound);
    end
  endtask

  // TX reference model: a byte queue drained one byte per PERIOD once the engine is free.
  logic [7:0] m_q[$], m_exp[$], stim_q[$];
  int         gap_in[$];
  int         m_k, m_next_free, m_dropped;

  task automatic model_edge(input bit push, input logic [7:0] d);
    if ((m_q.size() > 0) && (m_k >= m_next_free)) begin
      m_exp.push_back(m_q.pop_front());
      m_next_free = m_k + PERIOD;
    end
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else m_dropped++;
    end
    m_k++;
  endtask

  task automatic run_tx_stream(input string name);
    logic [7:0] s;
    int se;
    wait_idle(200);
    clear_mon();
    se = stable_err;
    m_q.delete(); m_exp.delete();
    m_k = 0; m_next_free = 0; m_dropped = 0;
    for (int i = 0; i < stim_q.size(); i++) begin
      for (int g = 0; g < gap_in[i]; g++) begin
        model_edge(1'b0, 8'h00);
        tick();
      end
      host_addr = ADDR_DATA; host_din = stim_q[i]; host_wr = 1'b1;
      model_edge(1'b1, stim_q[i]);
      tick();
      host_wr = 1'b0;
    end
    host_read(ADDR_CTRL, s);
    n_tests++;
    if (s[ST_TX_FULL] !== (m_q.size() == DEPTH) || s[ST_TX_EMPTY] !== (m_q.size() == 0)) begin
      n_fail++;
      $display("FAIL %s_txflags: got status %h, required full=%0d empty=%0d",
               name, s, m_q.size() == DEPTH, m_q.size() == 0);
    end
    while (m_q.size() > 0) m_exp.push_back(m_q.pop_front());
    wait_idle(400);
    n_tests++;
    if (wq.size() != m_exp.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d strobes, required %0d (dropped %0d)",
               name, wq.size(), m_exp.size(), m_dropped);
    end
    for (int i = 0; i < wq.size() && i < m_exp.size(); i++) begin
      n_tests++;
      if (wq[i] !== m_exp[i]) begin
        n_fail++;
        $display("FAIL %s_byte%0d: got %h, required %h", name, i, wq[i], m_exp[i]);
      end
    end
    foreach (wwid[i]) begin
      n_tests++;
      if (wwid[i] != PULSE_W) begin
        n_fail++;
        $display("FAIL %s_width%0d: got %0d, required %0d", name, i, wwid[i], PULSE_W);
      end
    end
    foreach (gapq[i]) begin
      n_tests++;
      if (gapq[i] < GAP_W) begin
        n_fail++;
        $display("FAIL %s_gap%0d: got %0d, required >= %0d", name, i, gapq[i], GAP_W);
      end
    end
    n_tests++;
    if (stable_err != se) begin
      n_fail++;
      $display("FAIL %s_stable: got %0d changes, required 0", name, stable_err - se);
    end
  endtask

  task automatic test_reset();
    logic [7:0] s;
    rstn = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (host_dout !== 8'h00 || disk_data_in !== 8'h00 || disk_data_clkin !== 1'b0 ||
        disk_data_clkout !== 1'b0 || disk_cr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dout=%h din=%h ci=%b co=%b cr=%h, required all 0",
               host_dout, disk_data_in, disk_data_clkin, disk_data_clkout, disk_cr);
    end
    rstn = 1'b1;
    tick();
    host_read(ADDR_CTRL, s);
    n_tests++;
    if (s !== 8'h50) begin n_fail++; $display("FAIL reset_status: got %h, required 50", s); end
    host_read(ADDR_CR, s);
    n_tests++;
    if (s !== 8'h00) begin n_fail++; $display("FAIL reset_rdreq: got %h, required 00", s); end
`ifdef DISK_BRIDGE_SR_IRQ_EN
    n_tests++;
    if (sr_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b, required 0", sr_irq); end
`endif
  endtask

  task automatic test_tx_basic();
    stim_q = '{8'hA5, 8'h3C};
    gap_in = '{0, 0};
    run_tx_stream("tx_basic");
    host_write(ADDR_DATA, 8'h5A);
    n_tests++;
    if (disk_data_clkin !== 1'b0) begin n_fail++; $display("FAIL latency_early: got %b, required 0", disk_data_clkin); end
    tick();
    n_tests++;
    if (disk_data_clkin !== 1'b1 || disk_data_in !== 8'h5A) begin
      n_fail++;
      $display("FAIL latency_rise: got clkin=%b data=%h, required 1/5a", disk_data_clkin, disk_data_in);
    end
    wait_idle(100);
  endtask

  task automatic test_tx_full();
    stim_q.delete(); gap_in.delete();
    for (int i = 0; i < 24; i++) begin stim_q.push_back(8'($urandom)); gap_in.push_back(0); end
    run_tx_stream("tx_full");
  endtask

  task automatic test_tx_random();
    stim_q.delete(); gap_in.delete();
    for (int i = 0; i < 30; i++) begin
      stim_q.push_back(8'($urandom));
      gap_in.push_back(int'($urandom_range(0, 9)));
    end
    run_tx_stream("tx_random");
  endtask

  task automatic test_rx_basic();
    logic [7:0] vals[4];
    logic [7:0] expv[4];
    logic [7:0] d;
    logic       prev;
    int         idx;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    expv = '{8'h11, 8'h22, 8'h33, 8'h00};
    wait_idle(100);
    clear_mon();
    idx = 0; prev = 1'b0;
    disk_data_out = vals[0];
    for (int i = 0; i < 60; i++) begin
      if (i < 3) host_write(ADDR_CTRL, 8'h02);
      else tick();
      if (disk_data_clkout && !prev && idx < 3) begin idx++; disk_data_out = vals[idx]; end
      prev = disk_data_clkout;
    end
    n_tests++;
    if (rwid.size() != 3) begin n_fail++; $display("FAIL rx_strobes: got %0d, required 3", rwid.size()); end
    foreach (rwid[i]) begin
      n_tests++;
      if (rwid[i] != PULSE_W) begin n_fail++; $display("FAIL rx_width%0d: got %0d, required %0d", i, rwid[i], PULSE_W); end
    end
    for (int i = 0; i < 4; i++) begin
      host_read(ADDR_DATA, d);
      n_tests++;
      if (d !== expv[i]) begin n_fail++; $display("FAIL rx_pop%0d: got %h, required %h", i, d, expv[i]); end
    end
  endtask

  task automatic test_regs();
    logic [7:0]  d;
    logic [31:0] crv, srv;
    logic [7:0]  expb[5];
    host_write(ADDR_SR, 8'h12); host_write(ADDR_SR, 8'h34);
    host_write(ADDR_SR, 8'h56); host_write(ADDR_SR, 8'h78);
    n_tests++;
    if (disk_cr !== 32'h0) begin n_fail++; $display("FAIL cr_early: got %h, required 00000000", disk_cr); end
    host_write(ADDR_CR, 8'h00);
    n_tests++;
    if (disk_cr !== 32'h12345678) begin n_fail++; $display("FAIL cr_load: got %h, required 12345678", disk_cr); end
    crv = $urandom;
    for (int i = 3; i >= 0; i--) host_write(ADDR_SR, crv[i*8 +: 8]);
    host_write(ADDR_CR, 8'h00);
    n_tests++;
    if (disk_cr !== crv) begin n_fail++; $display("FAIL cr_random: got %h, required %h", disk_cr, crv); end
    disk_sr = 32'hDEADBEEF;
    tick();
    host_write(ADDR_CTRL, 8'h04);
    srv = $urandom;
    disk_sr = srv;
    expb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hEF};
    for (int i = 0; i < 5; i++) begin
      host_read(ADDR_SR, d);
      n_tests++;
      if (d !== expb[i]) begin n_fail++; $display("FAIL snap_byte%0d: got %h, required %h", i, d, expb[i]); end
    end
    host_write(ADDR_CTRL, 8'h04);
    host_read(ADDR_SR, d);
    n_tests++;
    if (d !== srv[7:0]) begin n_fail++; $display("FAIL snap_reset_ptr: got %h, required %h", d, srv[7:0]); end
  endtask

  task automatic test_priority();
    bit exp_o[5];
    logic [7:0] d;
    exp_o = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    wait_idle(100);
    clear_mon();
    host_write(ADDR_DATA, 8'($urandom));
    host_write(ADDR_CTRL, 8'h02);
    host_write(ADDR_CTRL, 8'h02);
    host_write(ADDR_DATA, 8'($urandom));
    host_write(ADDR_DATA, 8'($urandom));
    wait_idle(200);
    n_tests++;
    if (order_q.size() != 5) begin n_fail++; $display("FAIL prio_count: got %0d strobes, required 5", order_q.size()); end
    for (int i = 0; i < 5 && i < order_q.size(); i++) begin
      n_tests++;
      if (order_q[i] !== exp_o[i]) begin n_fail++; $display("FAIL prio_order%0d: got %0d, required %0d (0=write 1=read)", i, order_q[i], exp_o[i]); end
    end
    host_read(ADDR_DATA, d);
    host_read(ADDR_DATA, d);
  endtask

  task automatic test_stall();
    logic [7:0] v, d;
    v = 8'($urandom);
    disk_data_out = v;
    wait_idle(100);
    clear_mon();
    repeat (18) host_write(ADDR_CTRL, 8'h02);
    wait_idle(300);
    repeat (20) tick();
    host_read(ADDR_CTRL, d);
    n_tests++;
    if (d !== 8'h61) begin n_fail++; $display("FAIL stall_status: got %h, required 61", d); end
    host_read(ADDR_CR, d);
    n_tests++;
    if (d !== 8'd2) begin n_fail++; $display("FAIL stall_rdreq: got %0d, required 2", d); end
    n_tests++;
    if (rwid.size() != DEPTH) begin n_fail++; $display("FAIL stall_strobes: got %0d, required %0d", rwid.size(), DEPTH); end
    repeat (260) host_write(ADDR_CTRL, 8'h02);
    host_read(ADDR_CR, d);
    n_tests++;
    if (d !== 8'd255) begin n_fail++; $display("FAIL rdreq_sat: got %0d, required 255", d); end
    host_read(ADDR_DATA, d);
    n_tests++;
    if (d !== v) begin n_fail++; $display("FAIL stall_pop: got %h, required %h", d, v); end
    wait_idle(100);
    host_read(ADDR_CR, d);
    n_tests++;
    if (d !== 8'd254 || rwid.size() != DEPTH + 1) begin
      n_fail++;
      $display("FAIL stall_resume: got rdreq=%0d strobes=%0d, required 254/%0d", d, rwid.size(), DEPTH + 1);
    end
    host_write(ADDR_CTRL, 8'h03);
    host_read(ADDR_CR, d);
    n_tests++;
    if (d !== 8'd1) begin n_fail++; $display("FAIL flush_rdreq: got %0d, required 1", d); end
    wait_idle(100);
    host_read(ADDR_DATA, d);
    n_tests++;
    if (d !== v) begin n_fail++; $display("FAIL flush_refill: got %h, required %h", d, v); end
    host_write(ADDR_CTRL, 8'h01);
    host_read(ADDR_CTRL, d);
    n_tests++;
    if (d !== 8'h50) begin n_fail++; $display("FAIL flush_status: got %h, required 50", d); end
  endtask

`ifdef DISK_BRIDGE_SR_IRQ_EN
  task automatic test_irq();
    host_write(ADDR_CTRL, 8'h04);
    tick();
    n_tests++;
    if (sr_irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear0: got %b, required 0", sr_irq); end
    disk_sr = disk_sr ^ 32'h20;
    tick();
    n_tests++;
    if (sr_irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b, required 1", sr_irq); end
    host_write(ADDR_CTRL, 8'h04);
    n_tests++;
    if (sr_irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b, required 0", sr_irq); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [7:0] d;
    wait_idle(100);
    host_write(ADDR_DATA, 8'($urandom));
    host_write(ADDR_DATA, 8'($urandom));
    host_write(ADDR_DATA, 8'($urandom));
    n_tests++;
    if (disk_data_clkin !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: got clkin %b, required 1", disk_data_clkin); end
    clear_mon();
    rstn = 1'b0;
    tick();
    n_tests++;
    if (disk_data_clkin !== 1'b0 || disk_data_in !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_drop: got clkin=%b data=%h, required 0/00", disk_data_clkin, disk_data_in);
    end
    rstn = 1'b1;
    tick();
    host_read(ADDR_CTRL, d);
    n_tests++;
    if (d !== 8'h50) begin n_fail++; $display("FAIL midreset_status: got %h, required 50", d); end
    repeat (30) tick();
    n_tests++;
    if (wq.size() != 0) begin n_fail++; $display("FAIL midreset_quiet: got %0d strobes, required 0", wq.size()); end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_rx_basic();
    test_tx_full();
    test_tx_random();
    test_regs();
    test_priority();
    test_stall();
`ifdef DISK_BRIDGE_SR_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
